regfile_wb_arbiter: RTL and testbench

Write-back arbiter and write-port sequencer for the 32×32 register file (one write port: `wen`, `rd`, `din`). It accepts write-back requests from N execution units over valid/ready handshakes, grants one per cycle round-robin, and drives the register-file write port from a registered stage. It also gives the issue stage a combinational busy query, so a read of a register with an in-flight write is stalled rather than returning stale data.

---
 rtl/regfile_wb_arbiter.sv | 108 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter that drives the register-file write port from a registered stage,
// with combinational busy checks for two source registers. Optional macro: WBARB_X0_DROP_EN.
module regfile_wb_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned PTR_W = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N-1:0]     req_valid_i,
  output logic [N-1:0]     req_ready_o,
  input  logic [5*N-1:0]   req_rd_i,
  input  logic [32*N-1:0]  req_data_i,
  output logic             rf_wen_o,
  output logic [4:0]       rf_rd_o,
  output logic [31:0]      rf_din_o,
  input  logic [4:0]       chk_rs1_i,
  input  logic [4:0]       chk_rs2_i,
  output logic             chk_busy1_o,
  output logic             chk_busy2_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             rf_wen_q, rf_wen_d;
  logic [4:0]       rf_rd_q, rf_rd_d;
  logic [31:0]      rf_din_q, rf_din_d;

  logic             gnt_found;
  logic [PTR_W-1:0] gnt_idx;
  logic [4:0]       gnt_rd;
  logic [31:0]      gnt_data;

  // Scan ptr, ptr+1, ... with explicit wrap at N, since N need not be a power of two.
  always_comb begin
    int unsigned idx;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_rd    = '0;
    gnt_data  = '0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!gnt_found && req_valid_i[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx[PTR_W-1:0];
        gnt_rd    = req_rd_i[5*idx +: 5];
        gnt_data  = req_data_i[32*idx +: 32];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (gnt_found && rst_ni) req_ready_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d    = ptr_q;
    rf_wen_d = 1'b0;
    rf_rd_d  = rf_rd_q;
    rf_din_d = rf_din_q;
    if (gnt_found) begin
      ptr_d    = (gnt_idx == PTR_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
      rf_rd_d  = gnt_rd;
      rf_din_d = gnt_data;
`ifdef WBARB_X0_DROP_EN
      rf_wen_d = (gnt_rd != 5'd0);
`else
      rf_wen_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= '0;
      rf_wen_q <= 1'b0;
      rf_rd_q  <= '0;
      rf_din_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rf_wen_q <= rf_wen_d;
      rf_rd_q  <= rf_rd_d;
      rf_din_q <= rf_din_d;
    end
  end

  // A source stays busy from request-valid until the write stage has presented it to the file.
  function automatic logic is_busy(input logic [4:0] rs);
    logic busy;
    busy = rf_wen_q && (rf_rd_q == rs);
    for (int unsigned i = 0; i < N; i++) begin
      if (req_valid_i[i] && (req_rd_i[5*i +: 5] == rs)) busy = 1'b1;
    end
`ifdef WBARB_X0_DROP_EN
    if (rs == 5'd0) busy = 1'b0;
`endif
    return busy;
  endfunction

  assign chk_busy1_o = is_busy(chk_rs1_i);
  assign chk_busy2_o = is_busy(chk_rs2_i);

  assign rf_wen_o = rf_wen_q;
  assign rf_rd_o  = rf_rd_q;
  assign rf_din_o = rf_din_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (N=3); expectations are hand-computed constants.
module tb_regfile_wb_arbiter;
  localparam int unsigned N = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [5*N-1:0]  req_rd;
  logic [32*N-1:0] req_data;
  logic            rf_wen;
  logic [4:0]      rf_rd;
  logic [31:0]     rf_din;
  logic [4:0]      chk_rs1, chk_rs2;
  logic            chk_busy1, chk_busy2;

  int n_total = 0;
  int n_bad   = 0;

  regfile_wb_arbiter #(.N(N)) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_rd_i    (req_rd),
    .req_data_i  (req_data),
    .rf_wen_o    (rf_wen),
    .rf_rd_o     (rf_rd),
    .rf_din_o    (rf_din),
    .chk_rs1_i   (chk_rs1),
    .chk_rs2_i   (chk_rs2),
    .chk_busy1_o (chk_busy1),
    .chk_busy2_o (chk_busy2)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester i targets rd = 10+i with data 0xA0A0_0000+i.
  logic [4:0]  rd_tab   [N];
  logic [31:0] data_tab [N];
  int          rr_seq   [6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    for (int i = 0; i < int'(N); i++) begin
      rd_tab[i]   = 5'(10 + i);
      data_tab[i] = 32'hA0A0_0000 + 32'(i);
      req_rd[5*i +: 5]    = rd_tab[i];
      req_data[32*i +: 32] = data_tab[i];
    end
    chk_rs1   = 5'd31;
    chk_rs2   = 5'd30;
    req_valid = '1;
    rst_n     = 1'b0;

    // Reset with all requests valid
    #3;
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    tick();
    check_eq("rst_wen", 32'(rf_wen), 32'h0);
    check_eq("rst_rd", 32'(rf_rd), 32'h0);
    check_eq("rst_din", rf_din, 32'h0);
    #2 rst_n = 1'b1;
    #1 check_eq("post_rst_ready", 32'(req_ready), 32'b001);

    // Full load round-robin
    for (int k = 0; k < 6; k++) begin
      int g;
      g = rr_seq[k];
      check_eq($sformatf("rr_ready%0d", k), 32'(req_ready), 32'(1 << g));
      tick();
      check_eq($sformatf("rr_wen%0d", k), 32'(rf_wen), 32'h1);
      check_eq($sformatf("rr_rd%0d", k), 32'(rf_rd), 32'(rd_tab[g]));
      check_eq($sformatf("rr_din%0d", k), rf_din, data_tab[g]);
    end

    // Single requester 2
    req_valid = 3'b100;
    req_rd[10 +: 5]   = 5'd5;
    req_data[64 +: 32] = 32'hDEADBEEF;
    #1 check_eq("single_ready", 32'(req_ready), 32'b100);
    tick();
    check_eq("single_wen", 32'(rf_wen), 32'h1);
    check_eq("single_rd", 32'(rf_rd), 32'd5);
    check_eq("single_din", rf_din, 32'hDEADBEEF);
    req_valid = 3'b111;
    #1 check_eq("single_ptr0", 32'(req_ready), 32'b001);
    req_valid = 3'b000;
    tick();
    check_eq("idle_wen", 32'(rf_wen), 32'h0);
    check_eq("idle_rd_hold", 32'(rf_rd), 32'd5);
    check_eq("idle_din_hold", rf_din, 32'hDEADBEEF);

    // Busy window on req 1, rd=7
    req_rd[5 +: 5] = 5'd7;
    chk_rs1   = 5'd7;
    chk_rs2   = 5'd8;
    req_valid = 3'b010;
    #1;
    check_eq("busy_ready", 32'(req_ready), 32'b010);
    check_eq("busy1_req", 32'(chk_busy1), 32'h1);
    check_eq("busy2_req", 32'(chk_busy2), 32'h0);
    tick();
    req_valid = 3'b000;
    #1;
    check_eq("busy1_wb", 32'(chk_busy1), 32'h1);
    check_eq("busy2_wb", 32'(chk_busy2), 32'h0);
    tick();
    check_eq("busy1_clear", 32'(chk_busy1), 32'h0);
    check_eq("busy2_clear", 32'(chk_busy2), 32'h0);

    // x0 write from req 0 (ptr is 2)
    req_rd[0 +: 5]    = 5'd0;
    req_data[0 +: 32] = 32'h1;
    chk_rs1   = 5'd0;
    req_valid = 3'b001;
    #1;
    check_eq("x0_ready", 32'(req_ready), 32'b001);
`ifdef WBARB_X0_DROP_EN
    check_eq("x0_busy_req", 32'(chk_busy1), 32'h0);
`else
    check_eq("x0_busy_req", 32'(chk_busy1), 32'h1);
`endif
    tick();
    req_valid = 3'b000;
    #1;
`ifdef WBARB_X0_DROP_EN
    check_eq("x0_wen", 32'(rf_wen), 32'h0);
    check_eq("x0_busy_wb", 32'(chk_busy1), 32'h0);
`else
    check_eq("x0_wen", 32'(rf_wen), 32'h1);
    check_eq("x0_rd", 32'(rf_rd), 32'h0);
    check_eq("x0_din", rf_din, 32'h1);
    check_eq("x0_busy_wb", 32'(chk_busy1), 32'h1);
`endif
    tick();
    req_rd[0 +: 5]    = rd_tab[0];
    req_data[0 +: 32] = data_tab[0];
    req_rd[5 +: 5]    = rd_tab[1];

    // Reset mid-stream (ptr is 1)
    req_valid = 3'b111;
    #1 check_eq("mid_ready", 32'(req_ready), 32'b010);
    tick();
    check_eq("mid_wen", 32'(rf_wen), 32'h1);
    check_eq("mid_rd", 32'(rf_rd), 32'(rd_tab[1]));
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_wen", 32'(rf_wen), 32'h0);
    check_eq("mid_rst_rd", 32'(rf_rd), 32'h0);
    check_eq("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    check_eq("mid_rst_wen_edge", 32'(rf_wen), 32'h0);
    #2 rst_n = 1'b1;
    #1 check_eq("mid_post_ptr0", 32'(req_ready), 32'b001);
    tick();
    check_eq("mid_post_rd", 32'(rf_rd), 32'(rd_tab[0]));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
